// File: rtl/avalon_slave_pkg.sv
// Shared types and helpers for the Avalon-MM pipelined-read slave.
package avalon_slave_pkg;

    localparam int unsigned DEF_NBDATABYTES = 2;
    localparam int unsigned DEF_NBADDRBITS  = 8;
    localparam int unsigned DATAW           = 8 * DEF_NBDATABYTES;

    typedef logic [DATAW-1:0]          data_t;
    typedef logic [DEF_NBADDRBITS-1:0] addr_t;

    // Width of a counter able to hold 0..maxpending inclusive.
    function automatic int unsigned clog2_pending(input int unsigned maxpending);
        return $clog2(maxpending + 1);
    endfunction

endpackage

// File: rtl/avalon_rsp_fifo.sv
// Synchronous response FIFO; a push into a full FIFO is legal when a pop happens the same cycle.
module avalon_rsp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = store[rd_ptr];

    // Storage array; contents need no reset since occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/avalon_pipeline_slave.sv
// Avalon-MM pipelined-read slave: on-chip memory, fixed-latency delay line,
// throttleable response FIFO and an outstanding-read counter.
module avalon_pipeline_slave
    import avalon_slave_pkg::*;
#(
    parameter int unsigned NBDATABYTES = 2,
    parameter int unsigned NBADDRBITS  = 8,
    parameter int unsigned FIXEDDELAY  = 2,
    parameter int unsigned MAXPENDING  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NBADDRBITS-1:0]                 address,
    input  logic [NBDATABYTES-1:0]                byteenable,
    input  logic [8*NBDATABYTES-1:0]              writedata,
    input  logic                                  read,
    input  logic                                  write,
    output logic                                  waitrequest,
    output logic [8*NBDATABYTES-1:0]              readdata,
    output logic                                  readdatavalid,
    input  logic                                  stall,
    input  logic                                  throttle,
    output logic [clog2_pending(MAXPENDING)-1:0]  pending,
    output logic                                  protocol_error
);

    localparam int unsigned W     = 8 * NBDATABYTES;
    localparam int unsigned DEPTH = 2 ** NBADDRBITS;
    localparam int unsigned PW    = clog2_pending(MAXPENDING);

    logic [W-1:0]  mem [DEPTH];
    logic          accept;
    logic          wr_acc;
    logic          rd_acc;
    logic [W-1:0]  rd_word;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [W-1:0]  fifo_din;
    logic [W-1:0]  fifo_dout;
    logic [PW-1:0] pending_d;

    // pending is registered, so a same-cycle return cannot release waitrequest early
    assign waitrequest = stall | (pending == PW'(MAXPENDING));
    assign accept      = (read | write) & ~waitrequest;
    assign wr_acc      = accept & write;
    // A simultaneous read+write is treated as a write only
    assign rd_acc      = accept & read & ~write;
    assign rd_word     = mem[address];
    assign fifo_pop    = ~fifo_empty & ~throttle;

    // Memory: cleared on reset, byte-lane writes on accepted writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc) begin
            for (int b = 0; b < NBDATABYTES; b++) begin
                if (byteenable[b]) begin
                    mem[address][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    generate
        if (FIXEDDELAY == 1) begin : g_nodelay
            assign fifo_push = rd_acc;
            assign fifo_din  = rd_word;
        end else begin : g_delay
            localparam int unsigned STAGES = FIXEDDELAY - 1;
            logic [STAGES-1:0] dly_vld;
            logic [W-1:0]      dly_data [STAGES];

            // Captured read words march one stage per cycle toward the FIFO
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dly_vld <= '0;
                    for (int s = 0; s < STAGES; s++) begin
                        dly_data[s] <= '0;
                    end
                end else begin
                    dly_vld[0]  <= rd_acc;
                    dly_data[0] <= rd_word;
                    for (int s = 1; s < STAGES; s++) begin
                        dly_vld[s]  <= dly_vld[s-1];
                        dly_data[s] <= dly_data[s-1];
                    end
                end
            end

            assign fifo_push = dly_vld[STAGES-1];
            assign fifo_din  = dly_data[STAGES-1];
        end
    endgenerate

    avalon_rsp_fifo #(
        .DEPTH (MAXPENDING),
        .WIDTH (W)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // pending bounds delay-line plus FIFO occupancy, so a blocked push cannot occur
    assert property (@(posedge clk) disable iff (!rst) fifo_push |-> (!fifo_full || fifo_pop));

    // Output stage: pop the FIFO head into the response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readdatavalid <= 1'b0;
            readdata      <= '0;
        end else begin
            readdatavalid <= fifo_pop;
            if (fifo_pop) begin
                readdata <= fifo_dout;
            end
        end
    end

    // Outstanding count drops on the edge that raises readdatavalid
    always_comb begin
        pending_d = pending;
        if (rd_acc && !fifo_pop) begin
            pending_d = pending + PW'(1);
        end else if (!rd_acc && fifo_pop) begin
            pending_d = pending - PW'(1);
        end
    end

    // Outstanding-read counter and sticky read+write error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending        <= '0;
            protocol_error <= 1'b0;
        end else begin
            pending <= pending_d;
            if (accept && read && write) begin
                protocol_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avalon_pipeline_slave.sv
// Directed bench for avalon_pipeline_slave (defaults: 2 bytes, 8 address bits, delay 2, 4 pending).
module tb_avalon_pipeline_slave;

    logic        clk;
    logic        rst;
    logic [7:0]  address;
    logic [1:0]  byteenable;
    logic [15:0] writedata;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [15:0] readdata;
    logic        readdatavalid;
    logic        stall;
    logic        throttle;
    logic [2:0]  pending;
    logic        protocol_error;

    int checks;
    int errors;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [1:0]  be;
        logic [15:0] wd;
        logic        rdv;
        logic [15:0] rdata;
        logic [2:0]  pend;
    } vec_t;

    vec_t vecs [14];

    avalon_pipeline_slave dut (
        .clk            (clk),
        .rst            (rst),
        .address        (address),
        .byteenable     (byteenable),
        .writedata      (writedata),
        .read           (read),
        .write          (write),
        .waitrequest    (waitrequest),
        .readdata       (readdata),
        .readdatavalid  (readdatavalid),
        .stall          (stall),
        .throttle       (throttle),
        .pending        (pending),
        .protocol_error (protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request for one clock, then land on the following falling edge
    task automatic cycle(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [1:0] be, input logic [15:0] wd);
        read       = rd;
        write      = wr;
        address    = a;
        byteenable = be;
        writedata  = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int acc;
        int nret;
        int viol;
        logic took;

        checks = 0;
        errors = 0;
        rst = 1'b0;
        address = '0;
        byteenable = '0;
        writedata = '0;
        read = 1'b0;
        write = 1'b0;
        stall = 1'b0;
        throttle = 1'b0;

        //            rd    wr    addr   be     wd        rdv   rdata     pend
        vecs[0]  = '{1'b0, 1'b1, 8'h05, 2'b11, 16'h1234, 1'b0, 16'h0000, 3'd0};
        vecs[1]  = '{1'b1, 1'b0, 8'h05, 2'b00, 16'h0000, 1'b0, 16'h0000, 3'd1};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 2'b00, 16'h0000, 1'b0, 16'h0000, 3'd1};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 2'b00, 16'h0000, 1'b1, 16'h1234, 3'd0};
        vecs[4]  = '{1'b0, 1'b1, 8'h07, 2'b11, 16'hFFFF, 1'b0, 16'h1234, 3'd0};
        vecs[5]  = '{1'b0, 1'b1, 8'h07, 2'b10, 16'hAB00, 1'b0, 16'h1234, 3'd0};
        vecs[6]  = '{1'b1, 1'b0, 8'h07, 2'b00, 16'h0000, 1'b0, 16'h1234, 3'd1};
        vecs[7]  = '{1'b0, 1'b1, 8'h03, 2'b11, 16'h0011, 1'b0, 16'h1234, 3'd1};
        vecs[8]  = '{1'b1, 1'b0, 8'h03, 2'b00, 16'h0000, 1'b1, 16'hABFF, 3'd1};
        vecs[9]  = '{1'b0, 1'b1, 8'h03, 2'b11, 16'h2222, 1'b0, 16'hABFF, 3'd1};
        vecs[10] = '{1'b1, 1'b0, 8'h03, 2'b00, 16'h0000, 1'b1, 16'h0011, 3'd1};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 2'b00, 16'h0000, 1'b0, 16'h0011, 3'd1};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 2'b00, 16'h0000, 1'b1, 16'h2222, 3'd0};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 2'b00, 16'h0000, 1'b0, 16'h2222, 3'd0};

        repeat (3) @(negedge clk);
        check("reset_state", {readdatavalid, readdata, pending, waitrequest, protocol_error}, 0);
        rst = 1'b1;

        // Table: {rdv, readdata, pending, waitrequest, protocol_error} after each edge
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd);
            check($sformatf("vec%0d", i),
                  {readdatavalid, readdata, pending, waitrequest, protocol_error},
                  {vecs[i].rdv, vecs[i].rdata, vecs[i].pend, 1'b0, 1'b0});
        end

        // Throttled burst of six reads to 0x10..0x15
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 8'h10 + 8'(i), 2'b11, 16'hA000 + 16'(i));
        end
        cycle(1'b0, 1'b0, 8'h00, 2'b00, 16'h0000);
        throttle = 1'b1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            read = (acc < 6);
            address = 8'h10 + 8'(acc);
            #1 took = read & ~waitrequest;
            @(posedge clk);
            @(negedge clk);
            if (took) acc++;
        end
        check("throttle_accepts", acc, 4);
        check("throttle_wait", waitrequest, 1);
        check("throttle_pending", pending, 4);

        throttle = 1'b0;
        nret = 0;
        viol = 0;
        for (int c = 0; c < 40 && !(nret == 6 && acc == 6); c++) begin
            read = (acc < 6);
            address = 8'h10 + 8'(acc);
            #1 took = read & ~waitrequest;
            @(posedge clk);
            @(negedge clk);
            if (took) acc++;
            if (readdatavalid) begin
                check($sformatf("order%0d", nret), readdata, 16'hA000 + 16'(nret));
                nret++;
            end
            if (nret > acc) viol++;
        end
        read = 1'b0;
        check("throttle_returns", nret, 6);
        check("rdv_le_accepts", viol, 0);
        check("pending_drained", pending, 0);

        // Stall held three cycles with a read waiting on address 9
        stall = 1'b1;
        read = 1'b1;
        address = 8'h09;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("stall_wait%0d", c), waitrequest, 1);
            check($sformatf("stall_pending%0d", c), pending, 0);
        end
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
        check("stall_accept", pending, 1);
        nret = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (readdatavalid) begin
                nret++;
                check("stall_data", readdata, 0);
            end
        end
        check("stall_one_rsp", nret, 1);

        // Read and write together: write wins, error is sticky
        cycle(1'b1, 1'b1, 8'h02, 2'b11, 16'h5555);
        check("rw_error", {protocol_error, readdatavalid, pending}, {1'b1, 1'b0, 3'd0});
        cycle(1'b1, 1'b0, 8'h02, 2'b00, 16'h0000);
        cycle(1'b0, 1'b0, 8'h00, 2'b00, 16'h0000);
        cycle(1'b0, 1'b0, 8'h00, 2'b00, 16'h0000);
        check("rw_mem", {readdatavalid, readdata, protocol_error}, {1'b1, 16'h5555, 1'b1});

        // Reset with two reads in flight
        cycle(1'b1, 1'b0, 8'h02, 2'b00, 16'h0000);
        cycle(1'b1, 1'b0, 8'h02, 2'b00, 16'h0000);
        read = 1'b0;
        check("inflight_pending", pending, 2);
        #2 rst = 1'b0;
        #1 check("async_reset", {readdatavalid, readdata, pending, protocol_error}, 0);
        @(negedge clk);
        rst = 1'b1;
        nret = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (readdatavalid) nret++;
        end
        check("no_rsp_after_reset", nret, 0);
        check("pending_after_reset", pending, 0);
        cycle(1'b1, 1'b0, 8'h02, 2'b00, 16'h0000);
        cycle(1'b0, 1'b0, 8'h00, 2'b00, 16'h0000);
        cycle(1'b0, 1'b0, 8'h00, 2'b00, 16'h0000);
        check("mem_cleared", {readdatavalid, readdata, protocol_error}, {1'b1, 16'h0000, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_pipeline_slave.md
Name: avalon_pipeline_slave

Overview:
- Avalon-MM pipelined-read slave with variable latency and on-chip storage. Sits directly downstream of the bus monitor/checker and answers the master's read/write requests.
- Generates waitrequest, readdata and readdatavalid, so the checker's pipeline properties are exercised by real traffic.
- Latency is normally fixed (FIXEDDELAY). It becomes variable when the bench asserts `throttle` or `stall`.

Parameters:
- NBDATABYTES, 2: data bytes per word; data width is 8*NBDATABYTES.
- NBADDRBITS, 8: word address width; memory depth is 2**NBADDRBITS.
- FIXEDDELAY, 2: nominal read latency in cycles, from acceptance to readdatavalid; must be >= 1.
- MAXPENDING, 4: maximum number of accepted reads not yet returned; also the response FIFO depth; must be >= 1.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- address  in  NBADDRBITS  word address.
- byteenable  in  NBDATABYTES  write byte lanes; ignored on reads.
- writedata  in  8*NBDATABYTES  write data.
- read  in  1  read request.
- write  in  1  write request.
- waitrequest  out  1  stall; a request is accepted only when this is low.
- readdata  out  8*NBDATABYTES  read response data.
- readdatavalid  out  1  readdata valid for this cycle.
- stall  in  1  test hook: forces waitrequest high.
- throttle  in  1  test hook: holds responses in the FIFO.
- pending  out  $clog2(MAXPENDING+1)  outstanding read count.
- protocol_error  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - readdatavalid=0, readdata=0, pending=0, protocol_error=0.
  - Delay line and FIFO are emptied.
  - All memory words are cleared to 0.
  - In-flight reads are discarded; none is ever returned.
- waitrequest = stall OR (pending == MAXPENDING). It is combinational from the registered count, so a return in the same cycle does not release it early.
- A request is accepted at a clock edge where (read OR write) AND NOT waitrequest.
  - While waitrequest is high the master holds its signals; the slave samples nothing.
- Write accept: mem[address] lane i <= writedata lane i for every i with byteenable[i]=1. The write is visible to reads accepted on later edges.
- Read accept:
  - mem[address] is captured at the acceptance edge.
  - A later write to the same address does not alter an in-flight read.
  - The captured word enters a delay line of FIXEDDELAY-1 stages, then the response FIFO.
  - With FIXEDDELAY=1 it goes straight to the FIFO.
- read AND write high together:
  - If the request is accepted, the write is performed, the read is ignored (pending unchanged) and protocol_error is set.
  - protocol_error stays set until reset.
- Output stage:
  - When the FIFO is non-empty and throttle=0, the head is popped into the readdata/readdatavalid registers.
  - Otherwise readdatavalid=0 and readdata holds its last value.
  - With throttle=0 throughout, readdatavalid is high exactly FIXEDDELAY cycles after the acceptance edge.
  - Responses are always returned in acceptance order.
- pending count:
  - +1 on read accept, -1 on each cycle with readdatavalid=1, unchanged when both happen in the same cycle.
  - Invariant: 0 <= pending <= MAXPENDING.
  - The FIFO plus delay line never overflows, because pending bounds their total occupancy.
- Back-to-back reads with no stall: one accepted per cycle, one returned per cycle; pending saturates at FIXEDDELAY if FIXEDDELAY < MAXPENDING.
- stall rising mid-burst: already-accepted reads still return normally.
- Idle cycles (no read, no write): no state change except responses draining from the delay line and FIFO.

Decomposition:
- Package avalon_slave_pkg holds:
  - data_t and addr_t typedefs derived from NBDATABYTES/NBADDRBITS defaults;
  - the function clog2_pending;
  - a localparam DATAW = 8*NBDATABYTES.
- Sub-module avalon_rsp_fifo: synchronous FIFO, depth MAXPENDING.
  - Ports: push, pop, din, dout, empty, full, same clk/rst.
  - Simultaneous push and pop on a full FIFO is legal.

Test Plan:
- Write 0x1234 to address 5 with byteenable=11, then read address 5 (FIXEDDELAY=2) -> readdatavalid=1 exactly 2 cycles after acceptance, readdata=0x1234, pending returns to 0.
- Write 0xFFFF to address 7, then 0xAB00 with byteenable=10, then read address 7 -> readdata=0xABFF.
- Six back-to-back reads with throttle=1 (MAXPENDING=4) -> waitrequest rises once pending=4, and exactly 4 reads are accepted. Release throttle -> 4 responses in order, the held reads then proceed, and the count of readdatavalid cycles always stays <= reads accepted.
- Read address 3 (content 0x0011), then write 0x2222 to address 3 on the next cycle -> the read returns 0x0011; a subsequent read returns 0x2222.
- stall=1 for 3 cycles while read is held with address 9 -> no acceptance and pending=0; after stall drops, one acceptance and one response.
- read and write high together on address 2 with data 0x5555 -> mem[2]=0x5555, no readdatavalid, protocol_error=1 until reset. Then drop rst with 2 reads in flight -> no readdatavalid afterwards, pending=0.
